// File: rtl/codeword_deserializer_if.sv
// Parallel codeword handshake between the deserializer and the decoder input.
interface codeword_deserializer_if #(
  parameter int WIDTH = 7
);
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/codeword_deserializer.sv
// Serial-line codeword receiver: synchronises ser_in, frames start/data/stop bits
// and hands each codeword to the decoder through a one-entry valid/ready register.
//
// state | meaning
// IDLE  | waiting for a start bit (tick sampling 0)
// DATA  | shifting in WIDTH data bits, LSB first
// STOP  | expecting the stop bit (1)
// BREAK | bad stop bit seen; wait for line to return high
module codeword_deserializer #(
  parameter int WIDTH       = 7,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   ser_in,
  input  logic                   bit_tick,
  codeword_deserializer_if.master out_if,
  output logic                   frame_err,
  output logic                   overrun,
  output logic                   busy
);
  typedef enum logic [1:0] {IDLE, DATA, STOP, BREAK} state_t;

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [SYNC_STAGES-1:0] sync;
  logic             ser_s;
  logic [WIDTH-1:0] shift;
  logic [CNT_W-1:0] bits_left;
  logic [WIDTH-1:0] data_q;
  logic             valid_q;
  logic             frame_done, frame_bad, cnt_load, shift_en;

  assign ser_s            = sync[SYNC_STAGES-1];
  assign busy             = (state != IDLE);
  assign out_if.out_data  = data_q;
  assign out_if.out_valid = valid_q;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    frame_done = 1'b0;
    frame_bad  = 1'b0;
    cnt_load   = 1'b0;
    shift_en   = 1'b0;
    if (bit_tick) begin
      case (state)
        IDLE: begin
          if (!ser_s) begin
            state_nxt = DATA;
            cnt_load  = 1'b1;
          end
        end
        DATA: begin
          shift_en = 1'b1;
          if (bits_left == '0) state_nxt = STOP;
        end
        STOP: begin
          if (ser_s) begin
            frame_done = 1'b1;
            state_nxt  = IDLE;
          end else begin
            frame_bad = 1'b1;
            state_nxt = BREAK;
          end
        end
        BREAK: begin
          if (ser_s) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Bits enter at the MSB and move down, so the first data bit ends up in bit 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync      <= '1;
      shift     <= '0;
      bits_left <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], ser_in};
      if (cnt_load) begin
        bits_left <= CNT_LOAD;
      end else if (shift_en) begin
        shift <= {ser_s, shift[WIDTH-1:1]};
        if (bits_left != '0) bits_left <= bits_left - 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= frame_bad;
      if (frame_done && (!valid_q || out_if.out_ready)) begin
        data_q  <= shift;
        valid_q <= 1'b1;
      end else begin
        if (frame_done) overrun <= 1'b1;
        if (valid_q && out_if.out_ready) valid_q <= 1'b0;
      end
    end
  end
endmodule
